pipe_if_id_reg: RTL and testbench
=================================

// Module: pipe_if_id_reg
// PURPOSE
//   PC register plus IF/ID pipeline latch for the 5-stage MIPS246 core.
//   Holds the current PC that drives instruction fetch, then captures the fetched instruction and its PC/PC+8 for decode.
//   Supports a load-use stall (freeze PC and IF/ID) and a branch/jump flush (squash IF/ID to a bubble).
//   Carries saturating stall/flush event counters for the bus/LED debug view.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   NOP_INST  32'h0000_0000  instruction injected on flush/reset (sll $0,$0,0)
//   CNT_W     16             width of stall_cnt / flush_cnt
// PORTS
//   clk        in   1      system clock, all state updates on rising edge
//   rst        in   1      asynchronous, active-high reset
//   if_npc     in   32     next PC selected by fetch-stage mux
//   if_inst    in   32     instruction read for current pc
//   if_pc8     in   32     pc+8 computed by fetch stage (jal/jalr link value)
//   stall      in   1      ID load-use hazard: hold PC and IF/ID
//   flush      in   1      taken branch/jump resolved in ID: squash IF/ID
//   pc         out  32     current PC, drives fetch
//   id_inst    out  32     instruction presented to decode
//   id_pc      out  32     PC of id_inst
//   id_pc8     out  32     pc+8 of id_inst
//   id_valid   out  1      1 = id_inst is a real instruction, 0 = bubble
//   stall_cnt  out  CNT_W  cycles with stall=1, saturating
//   flush_cnt  out  CNT_W  effective flushes, saturating
//   hz_err     out  1      sticky: stall and flush were asserted in the same cycle
// BEHAVIOUR
//   Reset (async, immediate): pc=RESET_PC, id_inst=NOP_INST, id_pc=0, id_pc8=0,
//     id_valid=0, stall_cnt=0, flush_cnt=0, hz_err=0. Reset mid-stall/flush drops all state.
//   First clk edge after rst falls: IF/ID captures instruction at RESET_PC; pc<=if_npc.
//   Per rising edge, priority (highest first):
//     1 stall=1 (flush ignored): pc, id_* all hold; stall_cnt+1; if flush=1 also set hz_err.
//     2 flush=1, stall=0: pc<=if_npc; id_inst<=NOP_INST, id_valid<=0, id_pc/id_pc8 <= 0; flush_cnt+1.
//     3 neither: pc<=if_npc; id_inst<=if_inst, id_pc<=pc, id_pc8<=if_pc8, id_valid<=1.
//   Latency: instruction at pc appears on id_inst exactly 1 cycle later (no stall).
//   pc is a plain 32-bit register; no alignment check, wraps naturally via if_npc.
//   Counters saturate at {CNT_W{1'b1}}, never wrap; only reset clears them.
//   hz_err stays 1 until reset.
//   All outputs are registered; no combinational input->output path.
// TESTING
//   1 rst=1 then release, if_npc=pc+4 -> pc: 0,4,8,...; id_valid=0 first cycle, then 1 with id_pc lagging pc by 1 cycle.
//   2 Running, stall=1 for 3 cycles at pc=0x10 -> pc and id_inst frozen 3 cycles, stall_cnt=3, then resume with no instruction lost or duplicated.
//   3 flush=1 one cycle with if_npc=0x40 -> next: pc=0x40, id_inst=NOP_INST, id_valid=0; following: id_pc=0x40, id_valid=1; flush_cnt=1.
//   4 stall=1 and flush=1 same cycle -> state held, flush_cnt unchanged, stall_cnt+1, hz_err=1 and stays 1.
//   5 CNT_W=4, stall held 20 cycles -> stall_cnt reaches 4'hF and stays 4'hF.
//   6 rst pulsed asynchronously mid-stall (between edges) -> all outputs reach reset values before next edge.

Source files
------------

// File: rtl/pipe_if_id_reg.sv
// rtl/pipe_if_id_reg.sv - PC register and IF/ID pipeline latch with stall/flush handling and debug counters
module pipe_if_id_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_npc,
    input  logic [31:0]      if_inst,
    input  logic [31:0]      if_pc8,
    input  logic             stall,
    input  logic             flush,
    output logic [31:0]      pc,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc8,
    output logic             id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hz_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      id_inst_q, id_inst_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic [31:0]      id_pc8_q, id_pc8_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hz_err_q, hz_err_d;

    always_comb begin
        pc_d        = pc_q;
        id_inst_d   = id_inst_q;
        id_pc_d     = id_pc_q;
        id_pc8_d    = id_pc8_q;
        id_valid_d  = id_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        hz_err_d    = hz_err_q;

        // A stall wins over a flush: the branch in ID is itself frozen and will re-flush later.
        if (stall) begin
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush) begin
                hz_err_d = 1'b1;
            end
        end else if (flush) begin
            pc_d       = if_npc;
            id_inst_d  = NOP_INST;
            id_pc_d    = 32'h0;
            id_pc8_d   = 32'h0;
            id_valid_d = 1'b0;
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else begin
            pc_d       = if_npc;
            id_inst_d  = if_inst;
            id_pc_d    = pc_q;
            id_pc8_d   = if_pc8;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            id_inst_q   <= NOP_INST;
            id_pc_q     <= 32'h0;
            id_pc8_q    <= 32'h0;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            hz_err_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            id_inst_q   <= id_inst_d;
            id_pc_q     <= id_pc_d;
            id_pc8_q    <= id_pc8_d;
            id_valid_q  <= id_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            hz_err_q    <= hz_err_d;
        end
    end

    assign pc        = pc_q;
    assign id_inst   = id_inst_q;
    assign id_pc     = id_pc_q;
    assign id_pc8    = id_pc8_q;
    assign id_valid  = id_valid_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign hz_err    = hz_err_q;

endmodule

// File: tb/tb_pipe_if_id_reg.sv
// tb/tb_pipe_if_id_reg.sv - table, directed and randomized checks of pipe_if_id_reg against a reference model
module tb_pipe_if_id_reg;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0BAD_F00D;
    localparam int          CW     = 4;
    localparam int          CMAX   = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   if_npc, if_inst, if_pc8;
    logic          stall, flush;
    logic [31:0]   pc, id_inst, id_pc, id_pc8;
    logic          id_valid;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          hz_err;

    pipe_if_id_reg #(.RESET_PC(RST_PC), .NOP_INST(NOP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .if_npc(if_npc), .if_inst(if_inst), .if_pc8(if_pc8),
        .stall(stall), .flush(flush), .pc(pc), .id_inst(id_inst), .id_pc(id_pc),
        .id_pc8(id_pc8), .id_valid(id_valid), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .hz_err(hz_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: the architectural view of what fetch/decode should see.
    logic [31:0] m_pc, m_inst, m_id_pc, m_id_pc8;
    logic        m_valid, m_hz;
    int          m_sc, m_fc;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_inst = NOP; m_id_pc = 0; m_id_pc8 = 0;
        m_valid = 0; m_hz = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".id_inst"}, id_inst, m_inst);
        chk({tag, ".id_pc"}, id_pc, m_id_pc);
        chk({tag, ".id_pc8"}, id_pc8, m_id_pc8);
        chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
        chk({tag, ".stall_cnt"}, {28'b0, stall_cnt}, m_sc);
        chk({tag, ".flush_cnt"}, {28'b0, flush_cnt}, m_fc);
        chk({tag, ".hz_err"}, {31'b0, hz_err}, {31'b0, m_hz});
    endtask

    // One clock: fetch supplies the word and link value for the PC the model believes is current.
    task automatic cycle(input logic s, input logic f, input logic [31:0] npc, input string tag);
        stall = s; flush = f; if_npc = npc;
        if_inst = imem(m_pc); if_pc8 = m_pc + 32'd8;
        @(posedge clk);
        if (s) begin
            m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            if (f) m_hz = 1'b1;
        end else if (f) begin
            m_pc = npc; m_inst = NOP; m_id_pc = 0; m_id_pc8 = 0; m_valid = 0;
            m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        end else begin
            m_inst = imem(m_pc); m_id_pc = m_pc; m_id_pc8 = m_pc + 32'd8; m_valid = 1;
            m_pc = npc;
        end
        #1;
        check_all(tag);
    endtask

    typedef struct {
        logic        s;
        logic        f;
        logic [31:0] npc;
        logic [31:0] e_pc;
        logic [31:0] e_id_pc;
        logic        e_valid;
        int          e_sc;
        int          e_fc;
        logic        e_hz;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{0, 0, 32'h04, 32'h04, 32'h00, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 32'h08, 32'h08, 32'h04, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 32'h0C, 32'h0C, 32'h08, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 32'h10, 32'h10, 32'h0C, 1, 0, 0, 0};
        tbl[4]  = '{1, 0, 32'h14, 32'h10, 32'h0C, 1, 1, 0, 0};
        tbl[5]  = '{1, 0, 32'h14, 32'h10, 32'h0C, 1, 2, 0, 0};
        tbl[6]  = '{1, 0, 32'h14, 32'h10, 32'h0C, 1, 3, 0, 0};
        tbl[7]  = '{0, 0, 32'h14, 32'h14, 32'h10, 1, 3, 0, 0};
        tbl[8]  = '{0, 1, 32'h40, 32'h40, 32'h00, 0, 3, 1, 0};
        tbl[9]  = '{0, 0, 32'h44, 32'h44, 32'h40, 1, 3, 1, 0};
        tbl[10] = '{1, 1, 32'h99, 32'h44, 32'h40, 1, 4, 1, 1};
        tbl[11] = '{0, 0, 32'h48, 32'h48, 32'h44, 1, 4, 1, 1};

        rst = 1'b1; stall = 0; flush = 0; if_npc = 0; if_inst = 0; if_pc8 = 0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].s, tbl[i].f, tbl[i].npc, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.exp_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d.exp_id_pc", i), id_pc, tbl[i].e_id_pc);
            chk($sformatf("tbl%0d.exp_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d.exp_sc", i), {28'b0, stall_cnt}, tbl[i].e_sc);
            chk($sformatf("tbl%0d.exp_fc", i), {28'b0, flush_cnt}, tbl[i].e_fc);
            chk($sformatf("tbl%0d.exp_hz", i), {31'b0, hz_err}, {31'b0, tbl[i].e_hz});
        end

        for (int i = 0; i < 20; i++) cycle(1, 0, 32'h1234, "sat");
        chk("sat.stall_cnt_max", {28'b0, stall_cnt}, 32'h0000_000F);
        cycle(0, 0, 32'h4C, "sat_resume");
        chk("sat.stall_cnt_hold", {28'b0, stall_cnt}, 32'h0000_000F);

        for (int i = 0; i < 300; i++) begin
            logic s, f;
            logic [31:0] npc;
            s = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 15);
            npc = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
            cycle(s, f, npc, $sformatf("rnd%0d", i));
        end
        chk("rnd.hz_sticky", {31'b0, hz_err}, 32'h1);

        cycle(1, 0, 32'h200, "pre_rst");
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        #1 rst = 1'b0;
        cycle(0, 0, 32'h04, "post_rst0");
        chk("post_rst0.id_inst_at_reset_pc", id_inst, imem(RST_PC));
        cycle(0, 0, 32'h08, "post_rst1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
